// File: rtl/mem_responder_pkg.sv
// Shared encodings for the memory responder: FSM states, grant source and the latency counter width.
package mem_responder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WAIT       = 3'd1,
      ST_GRANT_WR   = 3'd2,
      ST_COMMIT_WR  = 3'd3,
      ST_WR_RECOVER = 3'd4,
      ST_GRANT_RD   = 3'd5,
      ST_RD_RECOVER = 3'd6
   } state_t;

   typedef enum logic {
      SRC_WR = 1'b0,
      SRC_RD = 1'b1
   } grant_src_t;

   localparam int LAT_W = 4;

   function automatic state_t grant_state(input grant_src_t src);
      return (src == SRC_WR) ? ST_GRANT_WR : ST_GRANT_RD;
   endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Storage for the memory responder: one synchronous write port and one synchronous read port.
module mem_array #(
   parameter int DATA_W = 14,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_rd_en,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data
);

   logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] r_rd_data;

   // Contents survive reset; only the read register is cleared.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_data <= '0;
      end else if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/mem_responder.sv
// Arbitrating memory responder: grants one write or read at a time after a programmable wait,
// alternating between the two sides when both request.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int DATA_W   = 14,
   parameter int ADDR_W   = 12,
   parameter int WAIT_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ram_wr,
   output logic              ram_garant_wr,
   input  logic [DATA_W-1:0] data_in,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic              ram_rd,
   input  logic [ADDR_W-1:0] addr_rd,
   output logic              ram_garant_rd,
   output logic [DATA_W-1:0] data_rd
);

   localparam logic [LAT_W-1:0] C_WAIT_LAT = LAT_W'(WAIT_LAT);

   state_t           r_state, w_state_next;
   grant_src_t       r_winner, w_winner_next;
   grant_src_t       r_last, w_last_next;
   grant_src_t       w_pick;
   logic [LAT_W-1:0] r_lat_cnt, w_lat_cnt_next;
   logic             r_garant_wr, r_garant_rd;
   logic             w_winner_req;
   logic             w_wr_en, w_rd_en;

   // On contention the side that was not served last takes the grant.
   always_comb begin
      if (ram_wr && ram_rd) begin
         w_pick = (r_last == SRC_RD) ? SRC_WR : SRC_RD;
      end else if (ram_wr) begin
         w_pick = SRC_WR;
      end else begin
         w_pick = SRC_RD;
      end
   end

   assign w_winner_req = (r_winner == SRC_WR) ? ram_wr : ram_rd;

   always_comb begin
      w_state_next   = r_state;
      w_winner_next  = r_winner;
      w_last_next    = r_last;
      w_lat_cnt_next = r_lat_cnt;
      case (r_state)
         ST_IDLE: begin
            if (ram_wr || ram_rd) begin
               w_winner_next = w_pick;
               if (C_WAIT_LAT == '0) begin
                  w_state_next = grant_state(w_pick);
                  w_last_next  = w_pick;
               end else begin
                  w_lat_cnt_next = C_WAIT_LAT;
                  w_state_next   = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (!w_winner_req) begin
               w_lat_cnt_next = '0;
               w_state_next   = ST_IDLE;
            end else if (r_lat_cnt <= LAT_W'(1)) begin
               w_lat_cnt_next = '0;
               w_state_next   = grant_state(r_winner);
               w_last_next    = r_winner;
            end else begin
               w_lat_cnt_next = r_lat_cnt - LAT_W'(1);
            end
         end
         ST_GRANT_WR:   w_state_next = ST_COMMIT_WR;
         ST_COMMIT_WR:  w_state_next = ST_WR_RECOVER;
         ST_WR_RECOVER: if (!ram_wr) w_state_next = ST_IDLE;
         ST_GRANT_RD:   w_state_next = ST_RD_RECOVER;
         ST_RD_RECOVER: w_state_next = ST_IDLE;
         default:       w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_winner    <= SRC_WR;
         r_last      <= SRC_RD;
         r_lat_cnt   <= '0;
         r_garant_wr <= 1'b0;
         r_garant_rd <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_winner    <= w_winner_next;
         r_last      <= w_last_next;
         r_lat_cnt   <= w_lat_cnt_next;
         r_garant_wr <= (w_state_next == ST_GRANT_WR);
         r_garant_rd <= (w_state_next == ST_GRANT_RD);
      end
   end

   // Read is launched on the edge entering GRANT_RD so data lands with the grant pulse.
   assign w_wr_en = (r_state == ST_COMMIT_WR) && !reset;
   assign w_rd_en = (w_state_next == ST_GRANT_RD) && !reset;

   mem_array #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) u_mem_array (
      .clk      (clk),
      .reset    (reset),
      .i_wr_en  (w_wr_en),
      .i_wr_addr(addr_in),
      .i_wr_data(data_in),
      .i_rd_en  (w_rd_en),
      .i_rd_addr(addr_rd),
      .o_rd_data(data_rd)
   );

   assign ram_garant_wr = r_garant_wr;
   assign ram_garant_rd = r_garant_rd;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: three responders (WAIT_LAT 1, 3, 0) driven by tasks and checked against
// a behavioural memory/latency model.
module tb_mem_responder;

   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ram_wr   [NI];
   logic        ram_rd   [NI];
   logic [13:0] data_in  [NI];
   logic [11:0] addr_in  [NI];
   logic [11:0] addr_rd  [NI];
   logic        gwr      [NI];
   logic        grd      [NI];
   logic [13:0] data_rd  [NI];

   logic [13:0] mdl [NI][4096];

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      mem_responder #(
         .DATA_W  (14),
         .ADDR_W  (12),
         .WAIT_LAT((gi == 0) ? 1 : ((gi == 1) ? 3 : 0))
      ) dut (
         .clk          (clk),
         .reset        (reset),
         .ram_wr       (ram_wr[gi]),
         .ram_garant_wr(gwr[gi]),
         .data_in      (data_in[gi]),
         .addr_in      (addr_in[gi]),
         .ram_rd       (ram_rd[gi]),
         .addr_rd      (addr_rd[gi]),
         .ram_garant_rd(grd[gi]),
         .data_rd      (data_rd[gi])
      );
   end

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   // Full write transaction starting in IDLE; returns request-to-grant cycles and pulse-width flag.
   task automatic do_write(input int k, input logic [11:0] a, input logic [13:0] d,
                           output int lat, output logic pulse_long);
      lat = 0;
      ram_wr[k] = 1'b1;
      do begin
         step();
         lat++;
      end while (!gwr[k] && lat < 40);
      step();
      pulse_long = gwr[k];
      addr_in[k] = a;
      data_in[k] = d;
      ram_wr[k]  = 1'b0;
      mdl[k][a]  = d;
      step();
      addr_in[k] = 'z;
      data_in[k] = '0;
      step();
      $display("dut%0d write addr=%03h data=%04h lat=%0d", k, a, d, lat);
   endtask

   task automatic do_read(input int k, input logic [11:0] a,
                          output logic [13:0] d, output int lat, output logic pulse_long);
      lat = 0;
      ram_rd[k]  = 1'b1;
      addr_rd[k] = a;
      do begin
         step();
         lat++;
      end while (!grd[k] && lat < 40);
      d = data_rd[k];
      ram_rd[k] = 1'b0;
      step();
      pulse_long = grd[k];
      step();
      $display("dut%0d read  addr=%03h data=%04h lat=%0d", k, a, d, lat);
   endtask

   task automatic test_reset();
      for (int k = 0; k < NI; k++) begin
         ram_wr[k] = 1'b0; ram_rd[k] = 1'b0;
         data_in[k] = '0; addr_in[k] = 'z; addr_rd[k] = '0;
      end
      apply_reset();
      for (int k = 0; k < NI; k++) begin
         nchk++;
         if (gwr[k] !== 1'b0 || grd[k] !== 1'b0 || data_rd[k] !== 14'h0) begin
            nerr++;
            $display("FAIL reset_outputs dut%0d: got gwr=%b grd=%b data_rd=%04h, want 0 0 0000",
                     k, gwr[k], grd[k], data_rd[k]);
         end
      end
   endtask

   task automatic test_basic();
      int lat; logic pl; logic [13:0] d;
      do_write(0, 12'h010, 14'h1ABC, lat, pl);
      nchk++;
      if (lat != 2) begin nerr++; $display("FAIL basic_wr_lat: got %0d, want 2", lat); end
      nchk++;
      if (pl !== 1'b0) begin nerr++; $display("FAIL basic_wr_pulse: grant still %b after one cycle, want 0", pl); end
      do_read(0, 12'h010, d, lat, pl);
      nchk++;
      if (d !== 14'h1ABC) begin nerr++; $display("FAIL basic_rd_data: got %04h, want 1abc", d); end
      nchk++;
      if (lat != 2) begin nerr++; $display("FAIL basic_rd_lat: got %0d, want 2", lat); end
      nchk++;
      if (pl !== 1'b0) begin nerr++; $display("FAIL basic_rd_pulse: grant still %b after one cycle, want 0", pl); end
   endtask

   task automatic test_random();
      int lat; logic pl; logic [13:0] d; logic [11:0] a, ra;
      for (int k = 0; k < NI; k++) begin
         logic [11:0] q[$];
         for (int i = 0; i < 5; i++) begin
            a = 12'($urandom);
            do_write(k, a, 14'($urandom), lat, pl);
            q.push_back(a);
            nchk++;
            if (lat != lat_of(k) + 1 || pl !== 1'b0) begin
               nerr++;
               $display("FAIL rand_wr dut%0d: got lat=%0d pulse_long=%b, want lat=%0d pulse_long=0",
                        k, lat, pl, lat_of(k) + 1);
            end
            ra = q[$urandom_range(0, q.size() - 1)];
            do_read(k, ra, d, lat, pl);
            nchk++;
            if (d !== mdl[k][ra] || lat != lat_of(k) + 1) begin
               nerr++;
               $display("FAIL rand_rd dut%0d addr=%03h: got data=%04h lat=%0d, want data=%04h lat=%0d",
                        k, ra, d, lat, mdl[k][ra], lat_of(k) + 1);
            end
         end
      end
   endtask

   // Both sides keep requesting from reset; grants must alternate W,R,W,R and never coincide.
   task automatic test_back_to_back();
      logic [11:0] wa[4];
      logic [13:0] wd[4];
      int nw = 0, nr = 0, wph = 0, cyc = 0;
      bit first = 1'b1, last_w = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wa[i] = 12'($urandom);
         wd[i] = 14'($urandom);
      end
      apply_reset();
      ram_wr[0] = 1'b1; ram_rd[0] = 1'b1; addr_rd[0] = wa[0];
      while ((nw < 4 || nr < 4) && cyc < 300) begin
         step();
         cyc++;
         case (wph)
            1: begin
               addr_in[0] = wa[nw-1]; data_in[0] = wd[nw-1];
               mdl[0][wa[nw-1]] = wd[nw-1];
               ram_wr[0] = 1'b0; wph = 2;
            end
            2: begin addr_in[0] = 'z; wph = 3; end
            3: begin if (nw < 4) ram_wr[0] = 1'b1; wph = 0; end
            default: ;
         endcase
         nchk++;
         if (gwr[0] && grd[0]) begin
            nerr++;
            $display("FAIL b2b_exclusive: got both grants high at cycle %0d, want at most one", cyc);
         end
         if (gwr[0]) begin
            nchk++;
            if (!first && last_w) begin
               nerr++; $display("FAIL b2b_order: got W after W (grant %0d), want R", nw + nr);
            end
            first = 1'b0; last_w = 1'b1; nw++; wph = 1;
         end
         if (grd[0]) begin
            nchk++;
            if (first || !last_w) begin
               nerr++; $display("FAIL b2b_order: got R after %s, want R after W", first ? "reset" : "R");
            end
            nchk++;
            if (data_rd[0] !== mdl[0][wa[nr]]) begin
               nerr++; $display("FAIL b2b_rd_data addr=%03h: got %04h, want %04h", wa[nr], data_rd[0], mdl[0][wa[nr]]);
            end
            $display("dut0 b2b   read addr=%03h data=%04h", wa[nr], data_rd[0]);
            first = 1'b0; last_w = 1'b0; nr++;
            if (nr < 4) addr_rd[0] = wa[nr];
            else ram_rd[0] = 1'b0;
         end
      end
      nchk++;
      if (nw != 4 || nr != 4) begin
         nerr++; $display("FAIL b2b_count: got %0d writes %0d reads, want 4 and 4", nw, nr);
      end
      ram_wr[0] = 1'b0; ram_rd[0] = 1'b0; addr_in[0] = 'z;
      step(); step(); step();
   endtask

   task automatic test_hold_wr();
      int lat = 0, cnt = 0; logic pl; logic [13:0] d;
      ram_wr[0] = 1'b1;
      do begin step(); lat++; end while (!gwr[0] && lat < 40);
      step();
      addr_in[0] = 12'h5A5; data_in[0] = 14'h0F0F; mdl[0][12'h5A5] = 14'h0F0F;
      for (int i = 0; i < 5; i++) begin
         step();
         addr_in[0] = 'z;
         if (gwr[0]) cnt++;
      end
      nchk++;
      if (cnt != 0) begin nerr++; $display("FAIL hold_wr_regrant: got %0d extra grants, want 0", cnt); end
      ram_wr[0] = 1'b0;
      step();
      nchk++;
      if (gwr[0] !== 1'b0) begin nerr++; $display("FAIL hold_wr_release: got grant %b, want 0", gwr[0]); end
      do_write(0, 12'h5A6, 14'h2222, lat, pl);
      nchk++;
      if (lat != 2) begin nerr++; $display("FAIL hold_wr_second_lat: got %0d, want 2", lat); end
      do_read(0, 12'h5A5, d, lat, pl);
      nchk++;
      if (d !== 14'h0F0F) begin nerr++; $display("FAIL hold_wr_data: got %04h, want 0f0f", d); end
   endtask

   task automatic test_rd_drop();
      int lat, cnt = 0; logic pl; logic [13:0] d;
      do_write(1, 12'h2A0, 14'h1234, lat, pl);
      do_write(1, 12'h2A1, 14'h0ABC, lat, pl);
      do_read(1, 12'h2A0, d, lat, pl);
      nchk++;
      if (d !== 14'h1234 || lat != 4) begin
         nerr++; $display("FAIL drop_pre_read: got data=%04h lat=%0d, want 1234 lat=4", d, lat);
      end
      ram_rd[1] = 1'b1; addr_rd[1] = 12'h2A1;
      step();
      ram_rd[1] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (grd[1]) cnt++;
      end
      nchk++;
      if (cnt != 0) begin nerr++; $display("FAIL drop_no_grant: got %0d grants, want 0", cnt); end
      nchk++;
      if (data_rd[1] !== 14'h1234) begin nerr++; $display("FAIL drop_data_held: got %04h, want 1234", data_rd[1]); end
      do_read(1, 12'h2A1, d, lat, pl);
      nchk++;
      if (d !== 14'h0ABC || lat != 4) begin
         nerr++; $display("FAIL drop_back_idle: got data=%04h lat=%0d, want 0abc lat=4", d, lat);
      end
   endtask

   task automatic test_reset_commit();
      int lat = 0; logic pl; logic [13:0] d;
      do_write(0, 12'h3C3, 14'h2DB, lat, pl);
      do_read(0, 12'h3C3, d, lat, pl);
      ram_wr[0] = 1'b1;
      lat = 0;
      do begin step(); lat++; end while (!gwr[0] && lat < 40);
      step();
      addr_in[0] = 12'h3C3; data_in[0] = 14'h1524; ram_wr[0] = 1'b0; reset = 1'b1;
      step();
      nchk++;
      if (gwr[0] !== 1'b0 || grd[0] !== 1'b0 || data_rd[0] !== 14'h0) begin
         nerr++;
         $display("FAIL rst_commit_outputs: got gwr=%b grd=%b data_rd=%04h, want 0 0 0000",
                  gwr[0], grd[0], data_rd[0]);
      end
      reset = 1'b0; addr_in[0] = 'z; data_in[0] = '0;
      step();
      do_read(0, 12'h3C3, d, lat, pl);
      nchk++;
      if (d !== 14'h2DB) begin nerr++; $display("FAIL rst_commit_mem: got %04h, want 02db", d); end
   endtask

   task automatic test_wait0();
      int lat; logic pl; logic [13:0] d;
      do_write(2, 12'hFFF, 14'h3FFF, lat, pl);
      nchk++;
      if (lat != 1 || pl !== 1'b0) begin
         nerr++; $display("FAIL wait0_wr: got lat=%0d pulse_long=%b, want lat=1 pulse_long=0", lat, pl);
      end
      do_read(2, 12'hFFF, d, lat, pl);
      nchk++;
      if (d !== 14'h3FFF || lat != 1) begin
         nerr++; $display("FAIL wait0_rd: got data=%04h lat=%0d, want 3fff lat=1", d, lat);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_random();
      test_back_to_back();
      test_hold_wr();
      test_rd_drop();
      test_reset_commit();
      test_wait0();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
